// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                req_valid,
   input  logic [3*ADDR_W-1:0]       req_addr,
   input  logic [3*DATA_W-1:0]       req_data,
   output logic [2:0]                req_ready,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_addr,
   input  logic [ADDR_W-1:0]         rd_addr1,
   input  logic [ADDR_W-1:0]         rd_addr2,
   output logic                      hazard1,
   output logic                      hazard2,
   output logic [(1<<ADDR_W)-1:0]    busy,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic                      err_reissue
);

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   logic [3:0]              cnt1, cnt2;
   logic                    boost1, boost2;
   logic [2:0]              grant;
   logic [ADDR_W-1:0]       sel_addr;
   logic [DATA_W-1:0]       sel_data;
   logic [(1<<ADDR_W)-1:0]  busy_nxt;
   logic                    issue_set;

   assign boost1    = req_valid[1] && (cnt1 == LIM);
   assign boost2    = req_valid[2] && (cnt2 == LIM);
   assign issue_set = issue_valid && (issue_addr != '0);

   // Boosted requesters preempt the fixed 0 > 1 > 2 order; 1 wins a double boost.
   always_comb begin
      grant = 3'b000;
      if (rst)               grant = 3'b000;
      else if (boost1)       grant = 3'b010;
      else if (boost2)       grant = 3'b100;
      else if (req_valid[0]) grant = 3'b001;
      else if (req_valid[1]) grant = 3'b010;
      else if (req_valid[2]) grant = 3'b100;
   end

   assign req_ready = grant;

   always_comb begin
      sel_addr = req_addr[0 +: ADDR_W];
      sel_data = req_data[0 +: DATA_W];
      if (grant[1]) begin
         sel_addr = req_addr[ADDR_W +: ADDR_W];
         sel_data = req_data[DATA_W +: DATA_W];
      end else if (grant[2]) begin
         sel_addr = req_addr[2*ADDR_W +: ADDR_W];
         sel_data = req_data[2*DATA_W +: DATA_W];
      end
   end

   // Clear first so a same-cycle issue to the same register keeps it pending.
   always_comb begin
      busy_nxt = busy;
      if (grant[1] || grant[2])
         busy_nxt[sel_addr] = 1'b0;
      if (issue_set)
         busy_nxt[issue_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         busy        <= '0;
         err_reissue <= 1'b0;
         cnt1        <= 4'd0;
         cnt2        <= 4'd0;
      end else begin
         rf_we <= (grant != 3'b000) && (sel_addr != '0);
         if ((grant != 3'b000) && (sel_addr != '0)) begin
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
         end
         busy <= busy_nxt;
         if (issue_set && busy[issue_addr])
            err_reissue <= 1'b1;

         if (!req_valid[1] || grant[1]) cnt1 <= 4'd0;
         else if (cnt1 != LIM)          cnt1 <= cnt1 + 4'd1;
         if (!req_valid[2] || grant[2]) cnt2 <= 4'd0;
         else if (cnt2 != LIM)          cnt2 <= cnt2 + 4'd1;
      end
   end

   assign hazard1 = !rst && (rd_addr1 != '0) && busy[rd_addr1];
   assign hazard2 = !rst && (rd_addr2 != '0) && busy[rd_addr2];

endmodule
